// File: rtl/hlsm_alu_sched.sv
// hlsm_alu_sched: round-robin shared signed ALU for N requesters (define HLSM_ALU_FIXED_PRIO_EN for fixed lowest-index priority)
module hlsm_alu_sched #(
  parameter int N = 4,
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N-1:0]       req,
  input  logic [3*N-1:0]     op,
  input  logic [WIDTH*N-1:0] a,
  input  logic [WIDTH*N-1:0] b,
  input  logic [N-1:0]       sel,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   res,
  output logic               err,
  output logic               busy
);
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] win;
  logic [2:0] lop;
  logic [WIDTH-1:0] la, lb, alu;
  logic lsel;
`ifdef HLSM_ALU_FIXED_PRIO_EN
  // lowest asserted request index wins
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[IW'(i)]) win = IW'(i);
  end
`else
  logic [IW-1:0] ptr;
  // first asserted request after the last winner wins; the last winner itself ranks lowest
  always_comb begin
    win = ptr;
    for (int k = N; k >= 1; k--)
      if (req[IW'((int'(ptr) + k) % N)]) win = IW'((int'(ptr) + k) % N);
  end
  // remember the last winner to rotate priority
  always_ff @(posedge Clk)
    if (Rst) ptr <= IW'(N - 1);
    else if (state == IDLE && |req) ptr <= win;
`endif
  // state register
  always_ff @(posedge Clk)
    if (Rst) state <= IDLE;
    else state <= nxt;
  // IDLE waits for a request, then one cycle each of EXEC and DONE
  always_comb begin
    nxt = (state == IDLE) ? (|req ? EXEC : IDLE) : (state == EXEC) ? DONE : IDLE;
  end
  // the ALU works only from the latched copy so early request drops are harmless
  always_comb begin
    alu = (lop == 3'd0) ? la + lb :
          (lop == 3'd1) ? la - lb :
          (lop == 3'd2) ? WIDTH'($signed(la) < $signed(lb)) :
          (lop == 3'd3) ? WIDTH'(la == lb) :
          (lop == 3'd4) ? la << lb[SW-1:0] :
          (lop == 3'd5) ? la >> lb[SW-1:0] :
          (lop == 3'd6) ? (lsel ? la : lb) : '0;
  end
  // grant and operand latch in IDLE, result and ack in EXEC, clear in DONE
  always_ff @(posedge Clk)
    if (Rst) begin
      gnt  <= '0;
      ack  <= '0;
      res  <= '0;
      err  <= 1'b0;
      lop  <= '0;
      la   <= '0;
      lb   <= '0;
      lsel <= 1'b0;
    end else if (state == IDLE) begin
      if (|req) begin
        gnt  <= N'(1) << win;
        lop  <= op[3*win +: 3];
        la   <= a[WIDTH*win +: WIDTH];
        lb   <= b[WIDTH*win +: WIDTH];
        lsel <= sel[win];
      end
    end else if (state == EXEC) begin
      res <= alu;
      ack <= gnt;
      err <= lop == 3'd7;
    end else begin
      gnt <= '0;
      ack <= '0;
      err <= 1'b0;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_hlsm_alu_sched.sv
// tb_hlsm_alu_sched: directed checks of arbitration, opcodes, timing and reset for hlsm_alu_sched
module tb_hlsm_alu_sched;
  localparam int N = 4;
  localparam int W = 32;
  logic Clk = 1'b0;
  logic Rst;
  logic [N-1:0] req, sel, gnt, ack;
  logic [3*N-1:0] op;
  logic [W*N-1:0] a, b;
  logic [W-1:0] res;
  logic err, busy;
  int nv = 0;
  int nf = 0;
  int cyc = 0;

  hlsm_alu_sched #(.N(N), .WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .op(op), .a(a), .b(b), .sel(sel),
    .gnt(gnt), .ack(ack), .res(res), .err(err), .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic set_op(input int i, input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    op[3*i +: 3] = o;
    a[W*i +: W] = av;
    b[W*i +: W] = bv;
    sel[i] = s;
  endtask

  task automatic do_reset;
    Rst = 1'b1;
    req = '0;
    op = '0;
    a = '0;
    b = '0;
    sel = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    nv++; if (gnt !== 4'b0000) begin nf++; $display("FAIL reset gnt: got %b want 0000", gnt); end
    nv++; if (ack !== 4'b0000) begin nf++; $display("FAIL reset ack: got %b want 0000", ack); end
    nv++; if (res !== 32'h0) begin nf++; $display("FAIL reset res: got %h want 00000000", res); end
    nv++; if (err !== 1'b0) begin nf++; $display("FAIL reset err: got %b want 0", err); end
    nv++; if (busy !== 1'b0) begin nf++; $display("FAIL reset busy: got %b want 0", busy); end
    @(negedge Clk);
    nv++; if (busy !== 1'b0 || gnt !== 4'b0000) begin nf++; $display("FAIL idle_no_req: got busy %b gnt %b want 0 0000", busy, gnt); end
  endtask

  task automatic do_op(input string nm, input int i, input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input logic [W-1:0] er, input logic ee);
    logic [N-1:0] g;
    g = 4'b0001 << i;
    set_op(i, o, av, bv, s);
    req = g;
    @(negedge Clk);
    nv++;
    if (gnt !== g || busy !== 1'b1 || ack !== 4'b0000)
      begin nf++; $display("FAIL %s grant: got gnt %b busy %b ack %b want %b 1 0000", nm, gnt, busy, ack, g); end
    @(negedge Clk);
    nv++;
    if (ack !== g || res !== er || err !== ee || busy !== 1'b1)
      begin nf++; $display("FAIL %s result: got ack %b res %h err %b busy %b want %b %h %b 1", nm, ack, res, err, busy, g, er, ee); end
    req = '0;
    @(negedge Clk);
    nv++;
    if (ack !== 4'b0000 || gnt !== 4'b0000 || err !== 1'b0 || busy !== 1'b0 || res !== er)
      begin nf++; $display("FAIL %s release: got ack %b gnt %b err %b busy %b res %h want 0000 0000 0 0 %h", nm, ack, gnt, err, busy, res, er); end
  endtask

  task automatic test_ops;
    do_op("add", 0, 3'd0, 32'd5, -32'sd7, 1'b0, 32'hFFFFFFFE, 1'b0);
    do_op("add_wrap", 2, 3'd0, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0);
    do_op("sub", 2, 3'd1, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 1'b0);
    do_op("lt_neg", 2, 3'd2, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd1, 1'b0);
    do_op("lt_signed", 2, 3'd2, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0);
    do_op("eq", 2, 3'd3, 32'd9, 32'd9, 1'b0, 32'd1, 1'b0);
    do_op("eq_ne", 2, 3'd3, 32'd9, 32'd8, 1'b0, 32'd0, 1'b0);
    do_op("shl", 2, 3'd4, 32'd3, 32'd33, 1'b0, 32'd6, 1'b0);
    do_op("shr", 2, 3'd5, 32'h80000000, 32'd31, 1'b0, 32'd1, 1'b0);
    do_op("mux0", 2, 3'd6, 32'd4, 32'd8, 1'b0, 32'd8, 1'b0);
    do_op("mux1", 2, 3'd6, 32'd4, 32'd8, 1'b1, 32'd4, 1'b0);
    do_op("illegal", 2, 3'd7, 32'd4, 32'd8, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_contention;
    int order[4];
    int t;
    logic [N-1:0] dropped;
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, 3'd0, W'(10 * i), 32'd1, 1'b0);
`ifdef HLSM_ALU_FIXED_PRIO_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 1, 2, 3};
`endif
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      do begin @(negedge Clk); t++; end while (ack === 4'b0000 && t < 8);
      nv++;
      if (ack !== (4'b0001 << order[k]) || res !== W'(10 * order[k] + 1))
        begin nf++; $display("FAIL contention_%0d: got ack %b res %h want %b %h", k, ack, res, 4'b0001 << order[k], W'(10 * order[k] + 1)); end
      if (k == 3) req = '0;
      else begin
        dropped = ack;
        req = req & ~dropped;
        repeat (2) @(negedge Clk);
`ifdef HLSM_ALU_FIXED_PRIO_EN
        req = req | (dropped & 4'b0011);
`endif
      end
    end
    t = 0;
    repeat (5) begin @(negedge Clk); if (ack !== 4'b0000) t++; end
    nv++; if (t != 0) begin nf++; $display("FAIL contention_extra_ack: got %0d acks want 0", t); end
  endtask

  task automatic test_back_to_back;
    int last, t;
    last = 0;
    set_op(1, 3'd0, 32'd1, 32'd100, 1'b0);
    req = 4'b0010;
    for (int j = 0; j < 3; j++) begin
      t = 0;
      do begin @(negedge Clk); t++; end while (ack === 4'b0000 && t < 8);
      nv++;
      if (ack !== 4'b0010 || res !== W'(101 + j))
        begin nf++; $display("FAIL b2b_%0d: got ack %b res %h want 0010 %h", j, ack, res, W'(101 + j)); end
      if (j > 0) begin
        nv++;
        if (cyc - last != 3) begin nf++; $display("FAIL b2b_spacing_%0d: got %0d want 3", j, cyc - last); end
      end
      last = cyc;
      req = '0;
      @(negedge Clk);
      if (j < 2) begin
        set_op(1, 3'd0, W'(j + 2), 32'd100, 1'b0);
        req = 4'b0010;
      end
    end
    t = 0;
    repeat (5) begin @(negedge Clk); if (ack !== 4'b0000) t++; end
    nv++; if (t != 0) begin nf++; $display("FAIL b2b_extra_ack: got %0d acks want 0", t); end
  endtask

  task automatic test_reset_midop;
    do_reset;
    do_op("pre_reset", 1, 3'd0, 32'd5, 32'd5, 1'b0, 32'd10, 1'b0);
    for (int i = 0; i < N; i++) set_op(i, 3'd0, W'(20 + i), 32'd0, 1'b0);
    req = 4'b1111;
    @(negedge Clk);
    nv++; if (gnt !== 4'b0100) begin nf++; $display("FAIL midop_grant: got %b want 0100", gnt); end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    nv++;
    if (gnt !== 4'b0000 || ack !== 4'b0000 || res !== 32'h0 || err !== 1'b0 || busy !== 1'b0)
      begin nf++; $display("FAIL midop_reset: got gnt %b ack %b res %h err %b busy %b want all zero", gnt, ack, res, err, busy); end
    @(negedge Clk);
    nv++; if (gnt !== 4'b0001 || ack !== 4'b0000) begin nf++; $display("FAIL midop_regrant: got gnt %b ack %b want 0001 0000", gnt, ack); end
    req = '0;
    @(negedge Clk);
    nv++; if (ack !== 4'b0001 || res !== 32'd20) begin nf++; $display("FAIL midop_after: got ack %b res %h want 0001 00000014", ack, res); end
    @(negedge Clk);
  endtask

  task automatic test_early_drop;
    set_op(3, 3'd1, 32'd50, 32'd8, 1'b0);
    req = 4'b1000;
    @(negedge Clk);
    nv++; if (gnt !== 4'b1000) begin nf++; $display("FAIL early_grant: got %b want 1000", gnt); end
    req = '0;
    set_op(3, 3'd0, 32'd999, 32'd999, 1'b1);
    @(negedge Clk);
    nv++;
    if (ack !== 4'b1000 || res !== 32'd42 || err !== 1'b0)
      begin nf++; $display("FAIL early_result: got ack %b res %h err %b want 1000 0000002a 0", ack, res, err); end
    @(negedge Clk);
    nv++; if (busy !== 1'b0 || ack !== 4'b0000) begin nf++; $display("FAIL early_idle: got busy %b ack %b want 0 0000", busy, ack); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ops;
    test_contention;
    test_back_to_back;
    test_reset_midop;
    test_early_drop;
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
